// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [2:0] {
    SETTLE,
    SAMPLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  // Lowest-index pressed row wins when several rows read low together.
  function automatic logic [1:0] first_low_row(input logic [3:0] pattern);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!pattern[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module keypad_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner for a 4x4 keypad: settle, sample, debounce, one event per press.
import keypad_pkg::*;

// state    | meaning
// SETTLE   | new column driven, row synchronizers clamped
// SAMPLE   | one-cycle look at rows_n
// DEBOUNCE | candidate press must stay identical to the captured pattern
// HELD     | key accepted, column frozen until all rows go high
// RELEASE  | rows high, waiting for a stable release
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic       sync_clamp,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  scan_state_t   state;
  logic [1:0]    col_idx;
  logic [1:0]    col_next;
  logic [3:0]    pattern;
  logic          rows_idle;
  logic          rows_match;
  logic          tmr_clear;
  logic          tmr_enable;
  logic          tmr_done;
  logic [CW-1:0] tmr_terminal;

  assign col_next     = col_idx + 2'd1;
  assign rows_idle    = (rows_n == 4'hF);
  assign rows_match   = (rows_n == pattern);
  assign tmr_terminal = (state == SETTLE) ? CW'(SETTLE_CYCLES - 1) : CW'(DEBOUNCE_CYCLES - 1);

  // Counter restarts on every state change so each window is counted from zero.
  always_comb begin
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    unique case (state)
      SETTLE: begin
        if (tmr_done) tmr_clear = 1'b1;
        else          tmr_enable = 1'b1;
      end
      SAMPLE:   tmr_clear = 1'b1;
      DEBOUNCE: begin
        if (!rows_match || tmr_done) tmr_clear = 1'b1;
        else                         tmr_enable = 1'b1;
      end
      HELD:     tmr_clear = 1'b1;
      RELEASE: begin
        if (!rows_idle || tmr_done) tmr_clear = 1'b1;
        else                        tmr_enable = 1'b1;
      end
      default:  tmr_clear = 1'b1;
    endcase
  end

  keypad_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .terminal (tmr_terminal),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SETTLE;
      col_idx    <= 2'd0;
      cols_n     <= 4'b1110;
      sync_clamp <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
      pattern    <= 4'hF;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SETTLE: begin
          if (tmr_done) begin
            state      <= SAMPLE;
            sync_clamp <= 1'b0;
          end
        end
        SAMPLE: begin
          if (rows_idle) begin
            col_idx    <= col_next;
            cols_n     <= ~(4'b0001 << col_next);
            sync_clamp <= 1'b1;
            state      <= SETTLE;
          end else begin
            pattern <= rows_n;
            state   <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!rows_match) begin
            col_idx    <= col_next;
            cols_n     <= ~(4'b0001 << col_next);
            sync_clamp <= 1'b1;
            state      <= SETTLE;
          end else if (tmr_done) begin
            key_valid <= 1'b1;
            key_code  <= {first_low_row(pattern), col_idx};
            state     <= HELD;
          end
        end
        HELD: begin
          if (rows_idle) state <= RELEASE;
        end
        RELEASE: begin
          if (!rows_idle) begin
            state <= HELD;
          end else if (tmr_done) begin
            col_idx    <= col_next;
            cols_n     <= ~(4'b0001 << col_next);
            sync_clamp <= 1'b1;
            state      <= SETTLE;
          end
        end
        default: begin
          state      <= SETTLE;
          sync_clamp <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated key matrix drives rows_n from cols_n.
module tb_keypad_scan_ctrl;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic       sync_clamp;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] pressed;   // bit row*4+col set = that switch is closed
  int          n_cmp;
  int          n_bad;
  int          kv_count;
  logic        prev_kv;

  keypad_scan_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .rows_n     (rows_n),
    .cols_n     (cols_n),
    .sync_clamp (sync_clamp),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Physical key matrix: a driven-low column pulls down rows of closed switches.
  task automatic apply();
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      if (cols_n[c] === 1'b0)
        for (int rr = 0; rr < 4; rr++)
          if (pressed[rr*4+c]) r[rr] = 1'b0;
    rows_n = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) begin
      check("kv_single_cycle", {7'd0, prev_kv}, 8'd0);
      kv_count++;
    end
    prev_kv = key_valid;
    apply();
  endtask

  function automatic logic [3:0] col_drive(input int c);
    return 4'hF ^ (4'h1 << c);
  endfunction

  function automatic logic [3:0] code_of(input logic [3:0] rows_pat, input int c);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (!rows_pat[i]) r = i;
    return {2'(r), 2'(c)};
  endfunction

  // From the reset state: each column is S settle cycles plus one sample cycle.
  task automatic check_scan(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cyc();
      check("scan_cols", {4'd0, cols_n}, {4'd0, col_drive((i / (S + 1)) % 4)});
      check("scan_clamp", {7'd0, sync_clamp}, {7'd0, (i % (S + 1)) != S});
      check("scan_kv", {7'd0, key_valid}, 8'd0);
    end
  endtask

  task automatic wait_kv(input string tag, input int lim);
    for (int k = 0; k < lim && key_valid !== 1'b1; k++) cyc();
    check(tag, {7'd0, key_valid}, 8'd1);
  endtask

  task automatic wait_sample(input string tag, input logic [3:0] cols, input int lim);
    for (int k = 0; k < lim && !(cols_n === cols && sync_clamp === 1'b0); k++) cyc();
    check(tag, {3'd0, sync_clamp, cols_n}, {4'd0, cols});
  endtask

  task automatic wait_leave(input string tag, input logic [3:0] cols, input logic [3:0] next, input int lim);
    for (int k = 0; k < lim && cols_n === cols; k++) cyc();
    check(tag, {4'd0, cols_n}, {4'd0, next});
  endtask

  initial begin
    int base;
    int c;
    logic [3:0] mask;
    logic [3:0] rpat;
    logic changed;

    n_cmp = 0; n_bad = 0; kv_count = 0; prev_kv = 1'b0;
    pressed = 16'h0;
    rows_n = 4'hF;
    reset = 1'b1;

    // 1: reset values, then idle scan across all four columns and back
    repeat (3) cyc();
    check("rst_cols", {4'd0, cols_n}, 8'h0E);
    check("rst_clamp", {7'd0, sync_clamp}, 8'd1);
    check("rst_kv", {7'd0, key_valid}, 8'd0);
    check("rst_code", {4'd0, key_code}, 8'd0);
    reset = 1'b0;
    check_scan(15);

    // 2: row 2 at column 1 held; pulse exactly D+1 cycles after the sample
    base = kv_count;
    pressed = 16'h0001 << (2*4 + 1);
    apply();
    wait_sample("t2_find_sample", 4'b1101, 40);
    for (int k = 1; k <= D + 1; k++) begin
      cyc();
      if (k <= D) check("t2_kv_early", {7'd0, key_valid}, 8'd0);
    end
    check("t2_kv", {7'd0, key_valid}, 8'd1);
    check("t2_code", {4'd0, key_code}, {4'd0, code_of(4'b1011, 1)});
    repeat (8) begin
      cyc();
      check("t2_hold_col", {4'd0, cols_n}, 8'h0D);
    end
    check("t2_pulses", 8'(kv_count - base), 8'd1);
    pressed = 16'h0;
    apply();
    wait_leave("t2_release_next", 4'b1101, 4'b1011, 20);

    // 3: bouncing press at column 2 row 0 is discarded, scan resumes at column 3
    base = kv_count;
    pressed = 16'h0004;
    apply();
    wait_sample("t3_find_sample", 4'b1011, 40);
    changed = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pressed = (((k / 2) % 2) == 0) ? 16'h0004 : 16'h0000;
      apply();
      cyc();
      if (!changed && cols_n !== 4'b1011) begin
        changed = 1'b1;
        check("t3_next_col", {4'd0, cols_n}, 8'h07);
      end
    end
    check("t3_col_moved", {7'd0, changed}, 8'd1);
    check("t3_no_kv", 8'(kv_count - base), 8'd0);
    pressed = 16'h0;
    apply();

    // 4: row 3 column 0, second key added, release glitch, then clean release
    base = kv_count;
    pressed = 16'h0001 << (3*4 + 0);
    apply();
    wait_kv("t4_kv", 60);
    check("t4_code", {4'd0, key_code}, {4'd0, code_of(4'b0111, 0)});
    pressed = pressed | (16'h0001 << (1*4 + 0));
    apply();
    repeat (6) cyc();
    check("t4_two_keys_col", {4'd0, cols_n}, 8'h0E);
    pressed = 16'h0;
    apply();
    cyc();
    cyc();
    pressed = 16'h0001 << (3*4 + 0);
    apply();
    repeat (4) cyc();
    check("t4_glitch_col", {4'd0, cols_n}, 8'h0E);
    check("t4_one_pulse", 8'(kv_count - base), 8'd1);
    pressed = 16'h0;
    apply();
    for (int k = 1; k <= D + 1; k++) begin
      cyc();
      check("t4_release_col", {4'd0, cols_n}, (k <= D) ? 8'h0E : 8'h0D);
    end

    // 5: rows 0 and 2 low at column 3, lowest row wins
    pressed = (16'h0001 << (0*4 + 3)) | (16'h0001 << (2*4 + 3));
    apply();
    wait_kv("t5_kv", 60);
    check("t5_code", {4'd0, key_code}, {4'd0, code_of(4'b1010, 3)});
    pressed = 16'h0;
    apply();
    wait_leave("t5_release_next", 4'b0111, 4'b1110, 20);

    // random single-column presses, possibly several rows at once
    for (int n = 0; n < 8; n++) begin
      base = kv_count;
      c = int'($urandom_range(0, 3));
      mask = 4'($urandom_range(1, 15));
      pressed = 16'h0;
      rpat = 4'hF;
      for (int r = 0; r < 4; r++)
        if (mask[r]) begin
          pressed[r*4 + c] = 1'b1;
          rpat[r] = 1'b0;
        end
      apply();
      wait_kv("rnd_kv", 60);
      check("rnd_code", {4'd0, key_code}, {4'd0, code_of(rpat, c)});
      check("rnd_col", {4'd0, cols_n}, {4'd0, col_drive(c)});
      repeat (3) cyc();
      pressed = 16'h0;
      apply();
      wait_leave("rnd_next_col", col_drive(c), col_drive((c + 1) % 4), 20);
      check("rnd_pulses", 8'(kv_count - base), 8'd1);
    end

    // 6: reset during DEBOUNCE, then during HELD
    base = kv_count;
    pressed = 16'h0001;
    apply();
    wait_sample("t6_find_sample", 4'b1110, 40);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("t6a_cols", {4'd0, cols_n}, 8'h0E);
    check("t6a_clamp", {7'd0, sync_clamp}, 8'd1);
    check("t6a_kv", {7'd0, key_valid}, 8'd0);
    check("t6a_code", {4'd0, key_code}, 8'd0);
    pressed = 16'h0;
    cyc();
    reset = 1'b0;
    check_scan(6);
    check("t6a_no_kv", 8'(kv_count - base), 8'd0);

    pressed = 16'h0001 << (1*4 + 0);
    apply();
    wait_kv("t6b_kv", 60);
    check("t6b_code", {4'd0, key_code}, {4'd0, code_of(4'b1101, 0)});
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("t6b_cols", {4'd0, cols_n}, 8'h0E);
    check("t6b_clamp", {7'd0, sync_clamp}, 8'd1);
    check("t6b_kv", {7'd0, key_valid}, 8'd0);
    check("t6b_code", {4'd0, key_code}, 8'd0);
    base = kv_count;
    pressed = 16'h0;
    cyc();
    reset = 1'b0;
    check_scan(9);
    check("t6b_no_kv", 8'(kv_count - base), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
